// File: rtl/pixel_instr_sequencer.sv
// Issues a fixed per-pixel RGB-averaging program into fetch/decode.
// Optional stall cycle counter: define SEQ_STALL_CNT_EN.
module pixel_instr_sequencer #(
  parameter int PIXELS   = 76800,
  parameter int ADDR_W   = 17,
  parameter int LOAD_GAP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              stall_i,
  output logic [31:0]       instr_o,
  output logic              instr_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] pixel_cnt_o
`ifdef SEQ_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  // The memory opcode already carries the immediate-offset bit.
  localparam logic [1:0] OPDATA   = 2'b10;
  localparam logic [1:0] OPMEMORY = 2'b01;
  localparam logic [1:0] OPIMM    = 2'b01;
  localparam logic [3:0] FNOP     = 4'h0;
  localparam logic [3:0] FLOAD    = 4'h1;
  localparam logic [3:0] FSUB     = 4'h2;
  localparam logic [3:0] FSTR_ONE = 4'h3;
  localparam logic [3:0] FADD     = 4'h4;
  localparam logic [3:0] FAVERAGE = 4'h8;

`ifdef SEQ_STALL_CNT_EN
  localparam logic ADD_S = 1'b1;
`else
  localparam logic ADD_S = 1'b0;
`endif

  localparam logic [3:0]        STEP_AVG1 = 4'(3 + LOAD_GAP);
  localparam logic [3:0]        STEP_AVG2 = 4'(4 + LOAD_GAP);
  localparam logic [3:0]        STEP_STR  = 4'(5 + LOAD_GAP);
  localparam logic [3:0]        STEP_LAST = 4'(6 + LOAD_GAP);
  localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(PIXELS);

  function automatic logic [31:0] enc(input logic [1:0] op, input logic [3:0] cmd,
                                      input logic s, input logic [3:0] rn,
                                      input logic [3:0] rd, input logic [11:0] src2);
    return {4'hE, op, 1'b0, cmd, s, rn, rd, src2};
  endfunction

  localparam logic [31:0] NOP_WORD = enc(OPDATA, FNOP, 1'b0, 4'd0, 4'd0, 12'd0);

  function automatic logic [31:0] init_word(input logic second);
    return second ? enc(OPDATA, FSUB, 1'b0, 4'd5, 4'd5, 12'd5)
                  : enc(OPDATA, FSUB, 1'b0, 4'd0, 4'd0, 12'd0);
  endfunction

  // Steps between the third load and the first AVERAGE fall through to NOP_WORD.
  function automatic logic [31:0] pix_word(input logic [3:0] step);
    logic [31:0] w;
    w = NOP_WORD;
    if (step == 4'd0)           w = enc(OPMEMORY, FLOAD, 1'b0, 4'd0, 4'd1, 12'd0);
    else if (step == 4'd1)      w = enc(OPMEMORY, FLOAD, 1'b0, 4'd0, 4'd2, 12'd1);
    else if (step == 4'd2)      w = enc(OPMEMORY, FLOAD, 1'b0, 4'd0, 4'd3, 12'd2);
    else if (step == STEP_AVG1) w = enc(OPDATA, FAVERAGE, 1'b0, 4'd1, 4'd4, 12'd2);
    else if (step == STEP_AVG2) w = enc(OPDATA, FAVERAGE, 1'b0, 4'd4, 4'd4, 12'd3);
    else if (step == STEP_STR)  w = enc(OPMEMORY, FSTR_ONE, 1'b0, 4'd5, 4'd4, 12'd0);
    else if (step == STEP_LAST) w = enc(OPDATA | OPIMM, FADD, ADD_S, 4'd0, 4'd0, 12'd3);
    return w;
  endfunction

  typedef enum logic [1:0] {IDLE, INIT, PIX, DONE} state_t;

  state_t              state_q;
  logic [3:0]          step_q;
  logic [3:0]          step_d;
  logic [ADDR_W-1:0]   pix_q;
  logic [ADDR_W-1:0]   pix_d;
  logic [31:0]         instr_q;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;

  assign step_d = step_q + 4'd1;
  assign pix_d  = pix_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      pix_q   <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= INIT;
            step_q  <= '0;
            pix_q   <= '0;
            instr_q <= init_word(1'b0);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        INIT: begin
          if (!stall_i) begin
            if (step_q == 4'd1) begin
              state_q <= PIX;
              step_q  <= '0;
              instr_q <= pix_word(4'd0);
            end else begin
              step_q  <= step_d;
              instr_q <= init_word(1'b1);
            end
          end
        end
        PIX: begin
          if (!stall_i) begin
            if (step_q == STEP_LAST) begin
              // Limit is compared against the incremented count, so it never wraps.
              pix_q  <= pix_d;
              step_q <= '0;
              if (pix_d == PIX_LAST) begin
                state_q <= DONE;
                instr_q <= NOP_WORD;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                instr_q <= pix_word(4'd0);
              end
            end else begin
              step_q  <= step_d;
              instr_q <= pix_word(step_d);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pixel_cnt_o   = pix_q;

`ifdef SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      stall_cnt_q <= '0;
    end else if (busy_q && stall_i && valid_q && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_instr_sequencer.sv
// Bench for pixel_instr_sequencer: two instances (PIXELS=2/GAP=2 and PIXELS=3/GAP=0)
// checked cycle by cycle against a word-list model under random and directed stalls.
module tb_pixel_instr_sequencer;

  localparam int P0 = 2;
  localparam int G0 = 2;
  localparam int P1 = 3;
  localparam int G1 = 0;

  localparam logic [1:0] OPDATA   = 2'b10;
  localparam logic [1:0] OPMEMORY = 2'b01;
  localparam logic [3:0] FNOP     = 4'h0;
  localparam logic [3:0] FLOAD    = 4'h1;
  localparam logic [3:0] FSUB     = 4'h2;
  localparam logic [3:0] FSTR_ONE = 4'h3;
  localparam logic [3:0] FADD     = 4'h4;
  localparam logic [3:0] FAVERAGE = 4'h8;

`ifdef SEQ_STALL_CNT_EN
  localparam logic ADD_S = 1'b1;
`else
  localparam logic ADD_S = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start0, stall0, start1, stall1;
  logic [31:0] instr0, instr1;
  logic vld0, vld1, busy0, busy1, done0, done1;
  logic [16:0] pcnt0, pcnt1;
  logic [31:0] scnt0, scnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pixel_instr_sequencer #(.PIXELS(P0), .ADDR_W(17), .LOAD_GAP(G0)) u0 (
    .clk(clk), .reset(rst), .start_i(start0), .stall_i(stall0),
    .instr_o(instr0), .instr_valid_o(vld0), .busy_o(busy0), .done_o(done0),
    .pixel_cnt_o(pcnt0)
`ifdef SEQ_STALL_CNT_EN
    , .stall_cnt_o(scnt0)
`endif
  );

  pixel_instr_sequencer #(.PIXELS(P1), .ADDR_W(17), .LOAD_GAP(G1)) u1 (
    .clk(clk), .reset(rst), .start_i(start1), .stall_i(stall1),
    .instr_o(instr1), .instr_valid_o(vld1), .busy_o(busy1), .done_o(done1),
    .pixel_cnt_o(pcnt1)
`ifdef SEQ_STALL_CNT_EN
    , .stall_cnt_o(scnt1)
`endif
  );

`ifndef SEQ_STALL_CNT_EN
  assign scnt0 = 32'd0;
  assign scnt1 = 32'd0;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic        vld;
    logic        busy;
    logic        done;
    logic [16:0] pcnt;
    logic [31:0] scnt;
  } obs_t;

  function automatic obs_t sample(input int w);
    obs_t o;
    if (w == 0) o = '{instr0, vld0, busy0, done0, pcnt0, scnt0};
    else        o = '{instr1, vld1, busy1, done1, pcnt1, scnt1};
    return o;
  endfunction

  task automatic drive(input int w, input logic s, input logic st);
    if (w == 0) begin start0 = s; stall0 = st; end
    else        begin start1 = s; stall1 = st; end
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  function automatic logic [31:0] enc(input logic [1:0] op, input logic [3:0] cmd,
                                      input logic s, input logic [3:0] rn,
                                      input logic [3:0] rd, input logic [11:0] src2);
    return {4'hE, op, 1'b0, cmd, s, rn, rd, src2};
  endfunction

  function automatic logic [31:0] nop_word();
    return enc(OPDATA, FNOP, 1'b0, 4'd0, 4'd0, 12'd0);
  endfunction

  function automatic int pix_of(input int w);
    return (w == 0) ? P0 : P1;
  endfunction

  function automatic int gap_of(input int w);
    return (w == 0) ? G0 : G1;
  endfunction

  task automatic check_idle(input int w, input string tag);
    obs_t o;
    o = sample(w);
    chk({tag, "_vld"}, 32'(o.vld), 32'd0);
    chk({tag, "_busy"}, 32'(o.busy), 32'd0);
    chk({tag, "_instr"}, o.instr, nop_word());
  endtask

  // One frame: model is the flat list of words the program must produce.
  task automatic run_frame(input int w, input int pct, input int stall_at, input bit pulse_start);
    logic [31:0] exp_q[$];
    obs_t o;
    int g, np, n, idx, cyc, stalls, held, nops;
    logic st;
    g  = gap_of(w);
    np = pix_of(w);
    exp_q.push_back(enc(OPDATA, FSUB, 1'b0, 4'd0, 4'd0, 12'd0));
    exp_q.push_back(enc(OPDATA, FSUB, 1'b0, 4'd5, 4'd5, 12'd5));
    for (int p = 0; p < np; p++) begin
      for (int k = 0; k < 3; k++)
        exp_q.push_back(enc(OPMEMORY, FLOAD, 1'b0, 4'd0, 4'(k + 1), 12'(k)));
      for (int k = 0; k < g; k++) exp_q.push_back(nop_word());
      exp_q.push_back(enc(OPDATA, FAVERAGE, 1'b0, 4'd1, 4'd4, 12'd2));
      exp_q.push_back(enc(OPDATA, FAVERAGE, 1'b0, 4'd4, 4'd4, 12'd3));
      exp_q.push_back(enc(OPMEMORY, FSTR_ONE, 1'b0, 4'd5, 4'd4, 12'd0));
      exp_q.push_back(enc(2'b11, FADD, ADD_S, 4'd0, 4'd0, 12'd3));
    end
    n = exp_q.size();
    idx = 0; cyc = 0; stalls = 0; held = 0; nops = 0;

    drive(w, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(w, 1'b0, 1'b0);
    while (idx < n && cyc < 400) begin
      o = sample(w);
      chk("word", o.instr, exp_q[idx]);
      chk("valid", 32'(o.vld), 32'd1);
      chk("busy", 32'(o.busy), 32'd1);
      chk("done_early", 32'(o.done), 32'd0);
      chk("pixcnt", 32'(o.pcnt), 32'((idx < 2) ? 0 : (idx - 2) / (7 + g)));
      if (idx == 2) begin
        chk("ld_opcode", 32'(o.instr[27:26]), 32'(OPMEMORY));
        chk("ld_cmd", 32'(o.instr[24:21]), 32'(FLOAD));
        chk("ld_rd", 32'(o.instr[15:12]), 32'd1);
      end
      if (idx == 8 + g) chk("add_imm", 32'(o.instr[11:0]), 32'd3);
      st = ($urandom_range(0, 99) < pct) || (idx == stall_at && held < 3);
      if (st && idx == stall_at) held++;
      drive(w, pulse_start ? 1'($urandom_range(0, 1)) : 1'b0, st);
      @(posedge clk); #1;
      if (st) stalls++;
      else begin
        if (idx >= 2 && o.instr == nop_word()) nops++;
        idx++;
      end
      cyc++;
    end
    chk("frame_timeout", 32'(idx), 32'(n));

    o = sample(w);
    chk("done_pulse", 32'(o.done), 32'd1);
    chk("done_busy", 32'(o.busy), 32'd0);
    chk("done_vld", 32'(o.vld), 32'd0);
    chk("done_instr", o.instr, nop_word());
    chk("final_pixcnt", 32'(o.pcnt), 32'(np));
    chk("pix_nops", 32'(nops), 32'(np * g));
`ifdef SEQ_STALL_CNT_EN
    chk("stall_cnt", o.scnt, 32'(stalls));
`endif
    drive(w, pulse_start, 1'($urandom_range(0, 1)));
    @(posedge clk); #1;
    drive(w, 1'b0, 1'b0);
    o = sample(w);
    chk("done_once", 32'(o.done), 32'd0);
    chk("after_vld", 32'(o.vld), 32'd0);
    chk("after_busy", 32'(o.busy), 32'd0);
`ifdef SEQ_STALL_CNT_EN
    chk("stall_cnt_hold", o.scnt, 32'(stalls));
`endif
    if (stall_at >= 0 && pct == 0) chk("directed_stalls", 32'(stalls), 32'd3);
  endtask

  initial begin
    obs_t o;
    rst = 1'b1;
    start0 = 1'b0; stall0 = 1'b0; start1 = 1'b0; stall1 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    for (int w = 0; w < 2; w++) begin
      check_idle(w, "reset");
      o = sample(w);
      chk("reset_done", 32'(o.done), 32'd0);
      chk("reset_pixcnt", 32'(o.pcnt), 32'd0);
      chk("reset_scnt", o.scnt, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Stall while idle must not start anything.
    drive(0, 1'b0, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    check_idle(0, "idle_stall");
    drive(0, 1'b0, 1'b0);

    run_frame(0, 0, -1, 1'b0);
    run_frame(1, 0, -1, 1'b0);
    run_frame(0, 0, 7, 1'b0);
    run_frame(1, 0, 5, 1'b0);
    run_frame(0, 30, -1, 1'b1);
    run_frame(1, 30, -1, 1'b1);

    // Reset at step 4 of the first pixel (6 accepted words).
    drive(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_idle(0, "midreset");
    o = sample(0);
    chk("midreset_pixcnt", 32'(o.pcnt), 32'd0);
    chk("midreset_done", 32'(o.done), 32'd0);

    // Start coincident with reset is ignored.
    drive(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_idle(0, "start_rst");
    rst = 1'b0;
    drive(0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_idle(0, "post_rst");

    for (int r = 0; r < 4; r++) run_frame(r % 2, 25, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
